count_event_monitor: RTL and testbench

- Sits directly downstream of the 8-bit `counter` and consumes its `value` output every cycle.
- Classifies each change of the counter value as one of: first sample, increment, wrap, or jump (reset or reload).
- Queues tagged event records in a small FIFO with a valid/ready output handshake.
- Keeps saturating statistics counters for wraps and dropped records.

---
 rtl/count_event_monitor.sv | 136 +++++++++++++
 tb/tb_count_event_monitor.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/count_event_monitor.sv
// Watches a free-running counter value, classifies each change (first/inc/wrap/jump) and
// queues tagged records in a small FIFO with valid/ready output and saturating statistics.
module count_event_monitor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value_in,
    input  logic             sample_en,
    output logic [WIDTH+1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       wrap_count,
    output logic [7:0]       drop_count,
    output logic [AW:0]      level
);

    localparam logic [1:0]       KindFirst = 2'b00;
    localparam logic [1:0]       KindInc   = 2'b01;
    localparam logic [1:0]       KindWrap  = 2'b10;
    localparam logic [1:0]       KindJump  = 2'b11;
    localparam logic [WIDTH-1:0] ValOne    = WIDTH'(1);
    localparam logic [AW-1:0]    PtrOne    = AW'(1);
    localparam logic [AW:0]      LvlOne    = (AW+1)'(1);
    localparam logic [AW:0]      LvlFull   = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [7:0]       wrap_cnt_q, wrap_cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [WIDTH+1:0] mem_q [DEPTH];

    logic             rec_valid;
    logic [1:0]       rec_kind;
    logic             is_wrap;
    logic             pop;
    logic             push;

    // Event classification against the previous sampled value.
    always_comb begin
        rec_valid = 1'b0;
        rec_kind  = KindFirst;
        is_wrap   = 1'b0;
        if (sample_en) begin
            if (!prev_valid_q) begin
                rec_valid = 1'b1;
                rec_kind  = KindFirst;
            end else if (value_in != prev_q) begin
                rec_valid = 1'b1;
                if (prev_q == '1 && value_in == '0) begin
                    rec_kind = KindWrap;
                    is_wrap  = 1'b1;
                end else if (value_in == prev_q + ValOne) begin
                    rec_kind = KindInc;
                end else begin
                    rec_kind = KindJump;
                end
            end
        end
    end

    always_comb begin
        pop          = (level_q != '0) && out_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push         = rec_valid && ((level_q < LvlFull) || pop);
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        wrap_cnt_d   = wrap_cnt_q;
        drop_cnt_d   = drop_cnt_q;

        if (sample_en) begin
            prev_d       = value_in;
            prev_valid_d = 1'b1;
        end
        if (is_wrap && wrap_cnt_q != 8'hFF) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end
        if (rec_valid && !push && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (push && !pop) begin
            level_d = level_q + LvlOne;
        end else if (pop && !push) begin
            level_d = level_q - LvlOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            wrap_cnt_q   <= '0;
            drop_cnt_q   <= '0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            wrap_cnt_q   <= wrap_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= {rec_kind, value_in};
        end
    end

    always_comb begin
        out_valid  = (level_q != '0);
        out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
        level      = level_q;
        wrap_count = wrap_cnt_q;
        drop_count = drop_cnt_q;
    end

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: hand-computed records, levels and statistics.
module tb_count_event_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  value_in;
    logic        sample_en;
    logic [9:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  wrap_count;
    logic [7:0]  drop_count;
    logic [2:0]  level;

    int vectors = 0;
    int miscompares = 0;

    count_event_monitor #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .sample_en  (sample_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wrap_count (wrap_count),
        .drop_count (drop_count),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [7:0] v, input logic rdy);
        value_in  = v;
        sample_en = 1'b1;
        out_ready = rdy;
        step();
    endtask

    task automatic idle(input logic rdy);
        sample_en = 1'b0;
        out_ready = rdy;
        step();
    endtask

    initial begin
        reset = 1'b0; value_in = 8'h00; sample_en = 1'b0; out_ready = 1'b0;
        step(); step(); step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_data", 32'(out_data), 32'h000);
        check("rst_wrap", 32'(wrap_count), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);

        // First sample after reset.
        reset = 1'b1;
        sample(8'h05, 1'b0);
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_data", 32'(out_data), 32'h005);
        check("first_level", 32'(level), 32'd1);
        idle(1'b1);
        check("first_pop_level", 32'(level), 32'd0);
        check("first_pop_valid", 32'(out_valid), 32'd0);

        // Free-running across the wrap; FD itself is a jump from 05.
        sample(8'hFD, 1'b1);
        check("fd_data", 32'(out_data), 32'h3FD);
        sample(8'hFE, 1'b1);
        check("inc_fe", 32'(out_data), 32'h1FE);
        check("inc_fe_level", 32'(level), 32'd1);
        sample(8'hFF, 1'b1);
        check("inc_ff", 32'(out_data), 32'h1FF);
        sample(8'h00, 1'b1);
        check("wrap_00", 32'(out_data), 32'h200);
        check("wrap_cnt", 32'(wrap_count), 32'd1);
        sample(8'h01, 1'b1);
        check("inc_01", 32'(out_data), 32'h101);
        check("wrap_drop", 32'(drop_count), 32'd0);

        // Counter reset mid-count.
        sample(8'h3A, 1'b1);
        check("jump_3a", 32'(out_data), 32'h33A);
        sample(8'h3A, 1'b1);
        check("same_no_rec", 32'(level), 32'd0);
        sample(8'h00, 1'b1);
        check("jump_00", 32'(out_data), 32'h300);
        check("jump_wrap_cnt", 32'(wrap_count), 32'd1);
        idle(1'b1);
        check("drain_a", 32'(level), 32'd0);

        // Six increments with no consumer: 4 stored, 2 dropped.
        for (int i = 1; i <= 6; i++) sample(8'(i), 1'b0);
        check("full_level", 32'(level), 32'd4);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_drop", 32'(drop_count), 32'd2);
        check("full_head", 32'(out_data), 32'h101);
        idle(1'b0);
        check("stall_hold", 32'(out_data), 32'h101);
        idle(1'b1);
        check("drain_02", 32'(out_data), 32'h102);
        check("drain_lvl3", 32'(level), 32'd3);
        idle(1'b1);
        check("drain_03", 32'(out_data), 32'h103);
        idle(1'b1);
        check("drain_04", 32'(out_data), 32'h104);
        idle(1'b1);
        check("drain_empty", 32'(level), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_data0", 32'(out_data), 32'h000);

        // Full with a simultaneous pop and push.
        for (int i = 7; i <= 10; i++) sample(8'(i), 1'b0);
        check("refill_level", 32'(level), 32'd4);
        sample(8'h0B, 1'b1);
        check("fullpp_level", 32'(level), 32'd4);
        check("fullpp_drop", 32'(drop_count), 32'd2);
        check("fullpp_head", 32'(out_data), 32'h108);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("tail_0b", 32'(out_data), 32'h10B);

        // Reset with three records queued.
        sample(8'h0C, 1'b0);
        sample(8'h0D, 1'b0);
        check("pre_rst_level", 32'(level), 32'd3);
        reset = 1'b0;
        sample(8'h0E, 1'b1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_wrap", 32'(wrap_count), 32'd0);
        check("mid_rst_drop", 32'(drop_count), 32'd0);
        reset = 1'b1;
        sample(8'h20, 1'b0);
        check("post_rst_first", 32'(out_data), 32'h020);
        check("post_rst_level", 32'(level), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
